// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD <-> binary converters.
// Also holds the digit-validity helper used at capture time.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          DIGIT_W    = 4;
    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam int          NUM_DIGITS = 4;
    localparam logic [13:0] MAX_VALUE  = 14'd9999;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_to_bin4_if.sv
// Start/done handshake, digit inputs and result outputs of bcd_to_bin4.
interface bcd_to_bin4_if #(
    parameter int VALUE_W = 14
) ();
    logic               start;
    logic [3:0]         A;
    logic [3:0]         B;
    logic [3:0]         C;
    logic [3:0]         D;
    logic [VALUE_W-1:0] value;
    logic               done;
    logic               busy;
    logic               err;

    modport master (output start, A, B, C, D, input value, done, busy, err);
    modport slave  (input start, A, B, C, D, output value, done, busy, err);
endinterface

// File: rtl/mul10_add.sv
// One Horner step: acc*10 + digit, with the multiply built from two shifts.
module mul10_add
    import bcd_pkg::*;
#(
    parameter int VALUE_W = 14
) (
    input  logic [VALUE_W-1:0] acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [VALUE_W-1:0] sum
);
    assign sum = (acc << 2'd3) + (acc << 2'd1) + VALUE_W'(digit);
endmodule

// File: rtl/bcd_to_bin4.sv
// Sequential four-digit BCD to binary converter, one Horner step per clock.
// Invalid digits are flagged at capture and force a zero result.
module bcd_to_bin4
    import bcd_pkg::*;
#(
    parameter int VALUE_W = 14
) (
    input logic          clk,
    input logic          rst,
    bcd_to_bin4_if.slave bus
);
    state_t               state_r;
    state_t               state_next_s;
    logic [15:0]          digits_r;
    logic [VALUE_W-1:0]   acc_r;
    logic [1:0]           step_r;
    logic [VALUE_W-1:0]   value_r;
    logic                 done_r;
    logic                 busy_r;
    logic                 err_r;
    logic                 load_s;
    logic                 step_en_s;
    logic                 finish_s;
    logic                 invalid_s;
    logic [DIGIT_W-1:0]   digit_s;
    logic [VALUE_W-1:0]   sum_s;

    assign invalid_s = digit_invalid(bus.A) | digit_invalid(bus.B) |
                       digit_invalid(bus.C) | digit_invalid(bus.D);

    mul10_add #(.VALUE_W(VALUE_W)) u_mul10_add (
        .acc   (acc_r),
        .digit (digit_s),
        .sum   (sum_s)
    );

    // Step counter selects A..D, most significant first.
    always_comb begin
        digit_s = digits_r[3:0];
        case (step_r)
            2'd0:    digit_s = digits_r[15:12];
            2'd1:    digit_s = digits_r[11:8];
            2'd2:    digit_s = digits_r[7:4];
            2'd3:    digit_s = digits_r[3:0];
            default: digit_s = digits_r[3:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control decode; start is ignored while accumulating.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_en_s    = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_next_s = ST_ACC;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_ACC: begin
                step_en_s = 1'b1;
                if (step_r == 2'd3) begin
                    finish_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACC;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; value only updates on DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits_r <= 16'd0;
            acc_r    <= '0;
            step_r   <= 2'd0;
            value_r  <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else if (load_s) begin
            digits_r <= {bus.A, bus.B, bus.C, bus.D};
            acc_r    <= '0;
            step_r   <= 2'd0;
            err_r    <= invalid_s;
            done_r   <= 1'b0;
            busy_r   <= 1'b1;
        end else if (step_en_s) begin
            acc_r  <= sum_s;
            step_r <= step_r + 2'd1;
            if (finish_s) begin
                value_r <= err_r ? '0 : sum_s;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
            end else begin
                value_r <= value_r;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    assign bus.value = value_r;
    assign bus.done  = done_r;
    assign bus.busy  = busy_r;
    assign bus.err   = err_r;

endmodule

// File: tb/tb_bcd_to_bin4.sv
// Self-checking bench for bcd_to_bin4: directed cases plus random digits
// compared against a decimal-arithmetic reference.
module tb_bcd_to_bin4;
    localparam int VALUE_W = 14;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    bcd_to_bin4_if #(.VALUE_W(VALUE_W)) bus ();

    bcd_to_bin4 #(.VALUE_W(VALUE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_value(input int a, input int b, input int c, input int d);
        if (a > 9 || b > 9 || c > 9 || d > 9) return 0;
        return a * 1000 + b * 100 + c * 10 + d;
    endfunction

    function automatic int ref_err(input int a, input int b, input int c, input int d);
        return (a > 9 || b > 9 || c > 9 || d > 9) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input int a, input int b, input int c, input int d);
        bus.A = 4'(a);
        bus.B = 4'(b);
        bus.C = 4'(c);
        bus.D = 4'(d);
    endtask

    // One conversion with start pulsed; optionally scramble digits after capture
    // or keep start high during the accumulation cycles.
    task automatic run_conv(input int a, input int b, input int c, input int d,
                            input bit scramble, input bit noisy, input string tag);
        set_digits(a, b, c, d);
        bus.start = 1'b1;
        tick();
        bus.start = noisy ? 1'b1 : 1'b0;
        if (scramble) set_digits(9, 9, 9, 9);
        check({tag, "_busy_acc"}, int'(bus.busy), 1);
        check({tag, "_done_acc"}, int'(bus.done), 0);
        for (int i = 0; i < 3; i++) tick();
        bus.start = 1'b0;
        check({tag, "_done_early"}, int'(bus.done), 0);
        tick();
        check({tag, "_done"}, int'(bus.done), 1);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_value"}, int'(bus.value), ref_value(a, b, c, d));
        check({tag, "_err"}, int'(bus.err), ref_err(a, b, c, d));
    endtask

    initial begin
        int ra, rb, rc, rd;
        int k;
        rst = 1'b0;
        bus.start = 1'b0;
        set_digits(0, 0, 0, 0);
        tick();
        tick();
        check("rst_value", int'(bus.value), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.err), 0);
        rst = 1'b1;
        tick();

        run_conv(1, 2, 3, 4, 1'b0, 1'b0, "c1234");
        run_conv(0, 0, 3, 6, 1'b1, 1'b0, "c36_scr");
        run_conv(9, 9, 9, 9, 1'b0, 1'b0, "c9999");
        run_conv(0, 0, 0, 0, 1'b0, 1'b1, "c0_noisy");
        run_conv(1, 2, 10, 4, 1'b0, 1'b0, "c_inv");
        run_conv(0, 0, 0, 7, 1'b0, 1'b0, "c7");

        // Start held high: DONE every fifth cycle.
        set_digits(5, 0, 0, 5);
        bus.start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("held_done_%0d", i), int'(bus.done), (i % 5 == 0) ? 1 : 0);
            if (i % 5 == 0) check($sformatf("held_value_%0d", i), int'(bus.value), 5005);
        end
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("held_tail_cycles", k, 3);
        check("held_tail_value", int'(bus.value), 5005);

        // Reset two cycles into accumulation.
        set_digits(4, 4, 4, 4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_err", int'(bus.err), 0);
        check("mid_rst_value", int'(bus.value), 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_done", int'(bus.done), 0);
        run_conv(0, 4, 2, 0, 1'b0, 1'b0, "c420");

        // Random digits, roughly a quarter of them drawn from the full nibble range.
        for (int n = 0; n < 25; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            rc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            rd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            run_conv(ra, rb, rc, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin4.md
# bcd_to_bin4

Sequential converter from four packed BCD digits to a 14-bit binary value, the inverse of the `bcd4digit` binary-to-BCD converter. It serves the display front-end when a value entered or edited digit-by-digit (A–D) must return to the binary domain. It uses a start/done handshake matching `bcd4digit`, with one Horner step (acc·10 + digit) per clock. Invalid BCD digits are flagged instead of converted.

## Interface
Parameters:
- `VALUE_W`, 14, binary output width; must be ≥ 14 so that 9999 fits.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  conversion request; sampled on the rising edge.
- `A`  input  4  thousands digit (most significant).
- `B`  input  4  hundreds digit.
- `C`  input  4  tens digit.
- `D`  input  4  ones digit (least significant).
- `value`  output  VALUE_W  binary result; valid while `done`=1.
- `done`  output  1  result valid; level-held.
- `busy`  output  1  conversion in progress.
- `err`  output  1  at least one captured digit was > 9; valid while `done`=1.

## Operation
- Reset (`rst`=0, asynchronous): state = IDLE; `value`=0, `done`=0, `busy`=0, `err`=0; accumulator, digit register and step counter cleared.
- FSM states: IDLE, ACC, DONE.
  - IDLE, `start`=1 → ACC. Capture A,B,C,D into the internal digit register. Clear the accumulator, the step counter and `err`. Set `done`=0 and `busy`=1.
  - ACC: each cycle, acc ← acc·10 + digit[step], with step 0..3 selecting A, B, C, D. On step 3 → DONE.
  - DONE: `value` ← final accumulator (or 0 if `err`). Set `done`=1 and `busy`=0. Hold until an accepted `start`.
  - DONE, `start`=1: same behaviour as IDLE `start`=1, so a new conversion begins and `done` drops.
- `start` asserted during ACC: ignored, with no effect on the captured digits or the result.
- Changes on A–D after capture do not affect the result.
- Validation: any captured digit in 4'hA–4'hF sets `err` at capture. The conversion still runs all 4 steps and `done` follows normal timing. Final `value` = 0.
- Arithmetic: multiply by 10 as (x<<3)+(x<<1), unsigned, at VALUE_W width. The maximum intermediate is 999·10+9 = 9999, so no overflow is possible with valid digits. Invalid digits may produce garbage in the accumulator, but it is masked by the `err` rule.
- `value` holds its last result until the next DONE entry, and is not cleared at start.

## Timing
- Start accepted at edge N. ACC steps occur at edges N+1..N+4. DONE is entered at N+4, so `done`=1, `value` and `err` are valid after edge N+4. Latency is 4 clocks from the accepting edge.
- `busy`=1 after edges N..N+3 and returns to 0 after edge N+4.
- `start` held high continuously gives back-to-back conversions. Each DONE lasts 1 cycle and a new capture happens at the next edge, for a period of 5 clocks.
- Reset asserted mid-ACC clears all outputs immediately (combinationally asynchronous). After release, IDLE is reached with no pending conversion.
- Reset released on the same edge as `start`=1: the start is not guaranteed to be taken. The bench applies start ≥1 cycle after release.

## Structure
- Shared package `bcd_pkg`:
  - state encoding (IDLE/ACC/DONE);
  - `DIGIT_W`=4;
  - `BCD_MAX`=4'd9;
  - `NUM_DIGITS`=4;
  - `MAX_VALUE`=14'd9999.
  
  These are shared with `bcd4digit`.
- One sub-module, `mul10_add`: combinational acc·10 + digit, parameterised on VALUE_W. Instantiated once in the datapath.
- FSM, step counter (2-bit), digit register (16-bit) and error flag stay in the top module.

## Test plan
- Digits 1,2,3,4, `start` pulse 1 cycle → 4 clocks later `done`=1, `value`=1234, `err`=0, `busy`=0.
- Digits 0,0,3,6 then change A–D to 9,9,9,9 one cycle after start → `value`=36 (captured digits only). Then start with 9,9,9,9 → `value`=9999.
- Digits 0,0,0,0 → `value`=0, `done`=1, `err`=0. Extra `start` pulses during ACC do not change latency or result.
- Digits 1,2,4'hA,4 → `done` at normal latency, `err`=1, `value`=0. Next start with 0,0,0,7 → `err`=0, `value`=7.
- `start` held high for 12 cycles with digits 5,0,0,5 → `done` pulses every 5 cycles, each with `value`=5005.
- `rst`=0 two cycles into ACC → `done`, `busy`, `err`, `value` all 0 immediately. After release, digits 0,4,2,0 → `value`=420.
